// File: rtl/num_entry_ctrl.sv
// Three-digit keypad entry controller: edge-detected key presses edit a
// cursor-selected BCD digit, OK confirms the value and holds it until ack.
module num_entry_ctrl #(
    parameter logic [3:0] KEY_NEXT  = 4'd12,
    parameter logic [3:0] KEY_DEL   = 4'd13,
    parameter logic [3:0] KEY_OK    = 4'd14,
    parameter logic [3:0] KEY_NONE  = 4'd15,
    parameter int         BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] key,
    input  logic       ack,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [1:0] pos,
    output logic [9:0] value,
    output logic       done,
    output logic       cursor_vis,
    output logic       err
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [9:0] digits_to_bin(input logic [3:0] h,
                                                 input logic [3:0] t,
                                                 input logic [3:0] u);
        return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(u);
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       key_q;
    logic [3:0]       d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [1:0]       pos_q, pos_d;
    logic [9:0]       value_q, value_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             vis_q, vis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_s;
    logic             restart_s;
    logic             wr_en_s;
    logic [3:0]       wr_val_s;

    // Next-state logic: en=0 overrides everything, then per-state key handling.
    always_comb begin
        press_s   = (key != KEY_NONE) && (key_q == KEY_NONE);
        state_d   = state_q;
        d2_d      = d2_q;
        d1_d      = d1_q;
        d0_d      = d0_q;
        pos_d     = pos_q;
        err_d     = 1'b0;
        restart_s = 1'b0;
        wr_en_s   = 1'b0;
        wr_val_s  = 4'd0;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ENTER;
                    d2_d    = 4'd0;
                    d1_d    = 4'd0;
                    d0_d    = 4'd0;
                    pos_d   = 2'd0;
                end
                ENTER: begin
                    if (press_s) begin
                        if (key == KEY_NEXT) begin
                            pos_d     = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
                            restart_s = 1'b1;
                        end else if (key == KEY_DEL) begin
                            wr_en_s   = 1'b1;
                            wr_val_s  = 4'd0;
                            pos_d     = (pos_q == 2'd0) ? 2'd0 : pos_q - 2'd1;
                            restart_s = 1'b1;
                        end else if (key == KEY_OK) begin
                            state_d = HOLD;
                        end else if (key <= 4'd9) begin
                            wr_en_s   = 1'b1;
                            wr_val_s  = key;
                            restart_s = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ENTER;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state_d = ENTER;
                        d2_d    = 4'd0;
                        d1_d    = 4'd0;
                        d0_d    = 4'd0;
                        pos_d   = 2'd0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (wr_en_s) begin
            case (pos_q)
                2'd0:    d2_d = wr_val_s;
                2'd1:    d1_d = wr_val_s;
                default: d0_d = wr_val_s;
            endcase
        end else begin
            wr_val_s = 4'd0;
        end

        // The cursor stays solid outside ENTER and restarts its phase on any edit.
        if ((state_q != ENTER) || (state_d != ENTER) || restart_s) begin
            cnt_d = '0;
            vis_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            vis_d = ~vis_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
            vis_d = vis_q;
        end

        done_d  = (state_d == HOLD);
        value_d = digits_to_bin(d2_q, d1_q, d0_q);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= KEY_NONE;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            pos_q   <= 2'd0;
            value_q <= 10'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            vis_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            pos_q   <= pos_d;
            value_q <= value_d;
            done_q  <= done_d;
            err_q   <= err_d;
            vis_q   <= vis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d2         = d2_q;
    assign d1         = d1_q;
    assign d0         = d0_q;
    assign pos        = pos_q;
    assign value      = value_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cursor_vis = vis_q;

endmodule

// File: tb/tb_num_entry_ctrl.sv
// Scenario and randomized bench for num_entry_ctrl against an integer-level
// reference model of the entry rules (BLINK_DIV = 4).
module tb_num_entry_ctrl;

    localparam logic [3:0] K_NEXT = 4'd12;
    localparam logic [3:0] K_DEL  = 4'd13;
    localparam logic [3:0] K_OK   = 4'd14;
    localparam logic [3:0] K_NONE = 4'd15;
    localparam int         BDIV   = 4;
    localparam logic [26:0] RST_VEC = {4'd0, 4'd0, 4'd0, 2'd0, 10'd0, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst, en, ack;
    logic [3:0] key;
    logic [3:0] d2, d1, d0;
    logic [1:0] pos;
    logic [9:0] value;
    logic       done, cursor_vis, err;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle 1=enter 2=hold; dig[0] is the hundreds digit.
    int         m_mode, m_pos, m_val, m_ticks;
    int         m_dig [3];
    bit         m_done, m_err, m_vis;
    logic [3:0] m_keyq;

    always #5 clk = ~clk;

    num_entry_ctrl #(.BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst(rst), .en(en), .key(key), .ack(ack),
        .d2(d2), .d1(d1), .d0(d0), .pos(pos), .value(value),
        .done(done), .cursor_vis(cursor_vis), .err(err)
    );

    function automatic logic [26:0] dut_vec();
        return {d2, d1, d0, pos, value, done, err, cursor_vis};
    endfunction

    function automatic logic [26:0] mdl_vec();
        return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 2'(m_pos), 10'(m_val),
                m_done, m_err, m_vis};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_val = 0; m_ticks = 0;
        m_dig = '{0, 0, 0};
        m_done = 1'b0; m_err = 1'b0; m_vis = 1'b1;
        m_keyq = K_NONE;
    endtask

    task automatic model_step();
        int n_mode, n_pos;
        int n_dig [3];
        bit press, restart, n_err;
        if (rst) begin
            model_reset();
            return;
        end
        n_mode = m_mode; n_pos = m_pos; n_dig = m_dig;
        restart = 1'b0; n_err = 1'b0;
        press = (key != K_NONE) && (m_keyq == K_NONE);
        if (!en) begin
            n_mode = 0;
        end else if (m_mode == 0) begin
            n_mode = 1; n_pos = 0; n_dig = '{0, 0, 0};
        end else if (m_mode == 1 && press) begin
            if (key == K_NEXT) begin
                n_pos = (m_pos + 1) % 3; restart = 1'b1;
            end else if (key == K_DEL) begin
                n_dig[m_pos] = 0; n_pos = (m_pos == 0) ? 0 : m_pos - 1; restart = 1'b1;
            end else if (key == K_OK) begin
                n_mode = 2;
            end else if (key < 10) begin
                n_dig[m_pos] = int'(key); restart = 1'b1;
            end else begin
                n_err = 1'b1;
            end
        end else if (m_mode == 2 && ack) begin
            n_mode = 1; n_pos = 0; n_dig = '{0, 0, 0};
        end
        m_val = 100 * m_dig[0] + 10 * m_dig[1] + m_dig[2];
        m_ticks = (m_mode == 1 && n_mode == 1 && !restart) ? m_ticks + 1 : 0;
        m_vis  = (n_mode != 1) || (((m_ticks / BDIV) % 2) == 0);
        m_mode = n_mode; m_pos = n_pos; m_dig = n_dig;
        m_done = (n_mode == 2); m_err = n_err;
        m_keyq = key;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ack = 1'b0; key = K_NONE;
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            errors++; $display("FAIL reset_async: got %h expected %h", dut_vec(), RST_VEC);
        end
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_entry();
        logic [3:0] seq [6];
        seq = '{4'd3, K_NEXT, 4'd7, K_NEXT, 4'd5, K_OK};
        en = 1'b1;
        cycle();
        foreach (seq[i]) begin
            for (int t = 0; t < 5; t++) begin
                key = (t < 3) ? seq[i] : K_NONE;
                cycle();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL entry_seq: got %h expected %h", dut_vec(), mdl_vec());
                end
            end
        end
        checks++;
        if ({d2, d1, d0, value, done} !== {4'd3, 4'd7, 4'd5, 10'd375, 1'b1}) begin
            errors++; $display("FAIL entry_result: got %0d/%0d/%0d value %0d done %b expected 3/7/5 value 375 done 1",
                               d2, d1, d0, value, done);
        end
        repeat (4) begin
            cycle();
            checks++;
            if (done !== 1'b1) begin
                errors++; $display("FAIL entry_done_held: got %b expected 1", done);
            end
        end
    endtask

    task automatic test_hold_ack();
        for (int t = 0; t < 5; t++) begin
            key = (t < 3) ? 4'd8 : K_NONE;
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL hold_press: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if ({d2, d1, d0, value, done} !== {4'd3, 4'd7, 4'd5, 10'd375, 1'b1}) begin
            errors++; $display("FAIL hold_frozen: got %0d/%0d/%0d value %0d done %b expected 3/7/5 value 375 done 1",
                               d2, d1, d0, value, done);
        end
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        checks++;
        if ({d2, d1, d0, pos, done} !== {4'd0, 4'd0, 4'd0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL hold_ack: got %0d/%0d/%0d pos %0d done %b expected 0/0/0 pos 0 done 0",
                               d2, d1, d0, pos, done);
        end
        ack = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || done !== 1'b0) begin
                errors++; $display("FAIL ack_in_enter: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_edit_wrap();
        logic [3:0] seq [5];
        seq = '{4'd9, K_NEXT, K_NEXT, K_NEXT, 4'd2};
        foreach (seq[i]) begin
            for (int t = 0; t < 4; t++) begin
                key = (t < 2) ? seq[i] : K_NONE;
                cycle();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL edit_seq: got %h expected %h", dut_vec(), mdl_vec());
                end
            end
        end
        checks++;
        if ({pos, d2, value} !== {2'd0, 4'd2, 10'd200}) begin
            errors++; $display("FAIL edit_wrap: got pos %0d d2 %0d value %0d expected pos 0 d2 2 value 200",
                               pos, d2, value);
        end
        key = K_DEL;
        cycle();
        key = K_NONE;
        cycle();
        checks++;
        if ({pos, d2} !== {2'd0, 4'd0}) begin
            errors++; $display("FAIL del_pos0: got pos %0d d2 %0d expected pos 0 d2 0", pos, d2);
        end
    endtask

    task automatic test_err_hold_key();
        int pulses = 0;
        int writes = 0;
        logic [11:0] prev;
        for (int t = 0; t < 8; t++) begin
            key = (t == 0) ? 4'd10 : (t == 4) ? 4'd11 : K_NONE;
            cycle();
            if (err === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL err_seq: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL err_pulses: got %0d expected 2", pulses);
        end
        prev = {d2, d1, d0};
        key = 4'd4;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if ({d2, d1, d0} !== prev) writes++;
            prev = {d2, d1, d0};
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL hold_key_seq: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        key = K_NONE;
        checks++;
        if (writes !== 1 || d2 !== 4'd4) begin
            errors++; $display("FAIL hold_key_once: got %0d writes d2 %0d expected 1 write d2 4", writes, d2);
        end
    endtask

    task automatic test_blink();
        logic exp_vis;
        cycle();
        key = K_NEXT;
        cycle();
        key = K_NONE;
        checks++;
        if (cursor_vis !== 1'b1) begin
            errors++; $display("FAIL blink_restart: got %b expected 1", cursor_vis);
        end
        for (int t = 1; t <= 16; t++) begin
            cycle();
            exp_vis = ((t / BDIV) % 2) == 0;
            checks++;
            if (cursor_vis !== exp_vis || dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL blink_phase t=%0d: got vis %b expected %b", t, cursor_vis, exp_vis);
            end
        end
    endtask

    task automatic test_reset_en();
        logic [3:0] seq [3];
        seq = '{4'd1, K_NEXT, 4'd2};
        en = 1'b0; cycle();
        en = 1'b1; cycle();
        foreach (seq[i]) begin
            key = seq[i]; cycle();
            key = K_NONE; cycle();
        end
        cycle();
        checks++;
        if (value !== 10'd120) begin
            errors++; $display("FAIL mid_value: got %0d expected 120", value);
        end
        rst = 1'b1; en = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", dut_vec(), RST_VEC);
        end
        cycle();
        rst = 1'b0;
        repeat (3) begin
            cycle();
            checks++;
            if (dut_vec() !== RST_VEC) begin
                errors++; $display("FAIL reset_needs_en: got %h expected %h", dut_vec(), RST_VEC);
            end
        end
        en = 1'b1; cycle();
        key = 4'd4; cycle(); key = K_NONE; cycle();
        key = K_OK; cycle(); key = K_NONE; cycle();
        checks++;
        if ({done, value} !== {1'b1, 10'd400}) begin
            errors++; $display("FAIL hold_400: got done %b value %0d expected done 1 value 400", done, value);
        end
        en = 1'b0; ack = 1'b1; key = 4'd7;
        cycle();
        ack = 1'b0; key = K_NONE;
        checks++;
        if ({done, value, d2} !== {1'b0, 10'd400, 4'd4} || dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL en_off_hold: got done %b value %0d d2 %0d expected done 0 value 400 d2 4",
                               done, value, d2);
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        for (int n = 0; n < 2000; n++) begin
            if (hold_left == 0) begin
                key = ($urandom_range(0, 9) < 4) ? K_NONE : 4'($urandom_range(0, 15));
                hold_left = $urandom_range(1, 4);
            end
            hold_left--;
            en  = ($urandom_range(0, 31) != 0);
            ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random n=%0d: got %h expected %h", n, dut_vec(), mdl_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_hold_ack();
        test_edit_wrap();
        test_err_hold_key();
        test_blink();
        test_reset_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
